// File: rtl/normalized_to_byte.sv
// normalized_to_byte
//
// Re-quantizes an unsigned 2.16 fixed-point normalized value to an 8-bit
// intensity: out = clamp(round_half_up(x * 255 / 65536), 0, 255).
// This is the inverse of the byte-to-2.16 normalization LUT, so every
// {2'b00, b, b} maps back to b, and 0x10000 maps to 255.
//
// Two-stage pipeline with valid/ready on both sides:
//   stage 1 : p = x*255 (26 bits) + s1_valid
//   stage 2 : rounded/clamped byte, sat flag, out_valid (drive out_*)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    2.16 input sample        in_valid / in_ready  input handshake
//   out_data   quantized byte           out_sat   sample was clamped
//   out_valid / out_ready               output handshake
//   sat_clear  synchronous clear of sat_count (wins over an increment)
//   sat_count  clamped samples delivered, saturating at all-ones
module normalized_to_byte #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [17:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             sat_clear,
    output logic [CNT_W-1:0] sat_count
);

    logic [25:0] s1_p;
    logic        s1_valid;

    logic        s1_adv;
    logic        s2_adv;
    logic        out_xfer;

    logic [25:0] p_next;
    logic [26:0] p_round;
    logic [10:0] r;
    logic        sat_next;
    logic [7:0]  byte_next;

    // A stage may load when it is empty or its content moves on this edge.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = rst_n && s1_adv;
    assign out_xfer = out_valid && out_ready;

    // x*255 without a multiplier.
    assign p_next = {in_data, 8'd0} - {8'd0, in_data};

    // Round half-up, then anything above 255 (x >= 0x10081) clamps.
    assign p_round   = {1'b0, s1_p} + 27'h0008000;
    assign r         = p_round[26:16];
    assign sat_next  = |r[10:8];
    assign byte_next = sat_next ? 8'hFF : r[7:0];

    // Pure datapath register: no reset needed, qualified by the handshake.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_p <= p_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_sat   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= byte_next;
                out_sat  <= sat_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= '0;
        end else if (out_xfer && out_sat && (sat_count != '1)) begin
            sat_count <= sat_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_normalized_to_byte.sv
// Testbench for normalized_to_byte: reference model of the quantization
// rule, scoreboard queue of expected outputs, and directed/random phases.
module tb_normalized_to_byte;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [17:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready;
    logic             sat_clear;
    logic [CNT_W-1:0] sat_count;

    normalized_to_byte #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_clear (sat_clear),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] kat_q[$];
    int         lat_q[$];
    int         exp_cnt = 0;
    int         cyc = 0;
    bit         chk_lat = 0;
    bit         rand_rdy = 0;

    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'd0;
    logic       hold_s = 1'b0;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {sat, byte} from plain integer arithmetic on the rule x*255/65536.
    function automatic logic [8:0] ref_conv(input logic [17:0] x);
        int unsigned r;
        r = (32'(x) * 255 + 32768) / 65536;
        if (r > 255) return {1'b1, 8'hFF};
        return {1'b0, r[7:0]};
    endfunction

    // Scoreboard / protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [8:0] e;
        logic [8:0] k;
        int         t;
        if (!rst_n) begin
            check_val("in_ready_in_reset", 32'(in_ready), 0);
            exp_q.delete();
            kat_q.delete();
            lat_q.delete();
            exp_cnt = 0;
            hold_v  = 1'b0;
        end else begin
            cyc++;
            check_val("sat_count", 32'(sat_count), 32'(exp_cnt));
            check_val("in_ready", 32'(in_ready), (exp_q.size() == 2 && !out_ready) ? 0 : 1);
            if (hold_v) begin
                check_val("hold_valid", 32'(out_valid), 1);
                check_val("hold_data", 32'(out_data), 32'(hold_d));
                check_val("hold_sat", 32'(out_sat), 32'(hold_s));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    t = lat_q.pop_front();
                    check_val("out_data", 32'(out_data), 32'(e[7:0]));
                    check_val("out_sat", 32'(out_sat), 32'(e[8]));
                    if (kat_q.size() != 0) begin
                        k = kat_q.pop_front();
                        check_val("known_data", 32'(out_data), 32'(k[7:0]));
                        check_val("known_sat", 32'(out_sat), 32'(k[8]));
                    end
                    if (chk_lat) check_val("latency", 32'(cyc - t), 2);
                    if (sat_clear) exp_cnt = 0;
                    else if (e[8] && exp_cnt != CNT_MAX) exp_cnt++;
                end
            end else if (sat_clear) begin
                exp_cnt = 0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_conv(in_data));
                lat_q.push_back(cyc);
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_s = out_sat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [17:0] x);
        int   n = 0;
        logic acc;
        in_data  = x;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) check_val("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_rdy  = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        tick();
        check_val("drain_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic clear_pulse();
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] edge_x[5];
        logic [8:0]  edge_e[5];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 18'd0;
        out_ready = 1'b0;
        sat_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Reset state
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_out_data", 32'(out_data), 0);
        check_val("rst_out_sat", 32'(out_sat), 0);
        check_val("rst_sat_count", 32'(sat_count), 0);
        check_val("rst_in_ready", 32'(in_ready), 1);

        // Round trip through the normalization encoding, back-to-back
        out_ready = 1'b1;
        chk_lat   = 1;
        for (int b = 0; b < 255; b++) begin
            kat_q.push_back({1'b0, 8'(b)});
            send({2'b00, 8'(b), 8'(b)});
        end
        kat_q.push_back({1'b0, 8'hFF});
        send(18'h10000);
        drain();
        check_val("roundtrip_sat_count", 32'(sat_count), 0);
        chk_lat = 0;

        // Rounding and clamp edges
        edge_x[0] = 18'h08000; edge_e[0] = {1'b0, 8'd128};
        edge_x[1] = 18'h07F7F; edge_e[1] = {1'b0, 8'd127};
        edge_x[2] = 18'h10080; edge_e[2] = {1'b0, 8'd255};
        edge_x[3] = 18'h10081; edge_e[3] = {1'b1, 8'd255};
        edge_x[4] = 18'h3FFFF; edge_e[4] = {1'b1, 8'd255};
        for (int i = 0; i < 5; i++) begin
            kat_q.push_back(edge_e[i]);
            send(edge_x[i]);
        end
        drain();
        check_val("edges_sat_count", 32'(sat_count), 2);

        // Random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) tick();
            send(18'($urandom_range(0, 18'h3FFFF)));
        end
        drain();

        // Counter saturation
        clear_pulse();
        for (int i = 0; i < 20; i++) begin
            send(18'($urandom_range(18'h10081, 18'h3FFFF)));
        end
        drain();
        check_val("sat_count_saturated", 32'(sat_count), CNT_MAX);
        repeat (3) tick();
        check_val("sat_count_holds", 32'(sat_count), CNT_MAX);

        // Clear colliding with a clamped output transfer
        out_ready = 1'b0;
        send(18'h20000);
        tick();
        check_val("collide_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        check_val("collide_sat_count", 32'(sat_count), 0);
        drain();

        // Reset with two samples in flight
        send(18'h3FFFF);
        drain();
        check_val("pre_reset_sat_count", 32'(sat_count), 1);
        out_ready = 1'b0;
        send(18'h12345);
        send(18'h20000);
        check_val("pre_reset_in_ready", 32'(in_ready), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("midrst_out_valid", 32'(out_valid), 0);
        check_val("midrst_out_data", 32'(out_data), 0);
        check_val("midrst_out_sat", 32'(out_sat), 0);
        check_val("midrst_sat_count", 32'(sat_count), 0);
        out_ready = 1'b1;
        repeat (4) tick();
        chk_lat = 1;
        kat_q.push_back({1'b0, 8'd1});
        send(18'h00101);
        drain();
        chk_lat = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
